// File: rtl/led_display_row_driver_pkg.sv
// Shared pixel-row types and widths for the LED panel path, plus the
// row driver's state encoding and HUB75 address width.
package led_display_row_driver_pkg;

  localparam int GL_NUM_COL_PIXELS = 32;
  localparam int GL_NUM_ROW_PIXELS = 32;
  localparam int GL_RGB_COL_W      = GL_NUM_COL_PIXELS;

  typedef struct packed {
    logic [GL_RGB_COL_W-1:0] blue;
    logic [GL_RGB_COL_W-1:0] green;
    logic [GL_RGB_COL_W-1:0] red;
  } rgb_half_t;

  // Packed order makes channel i (0 = top.red .. 5 = bot.blue) line up with
  // panel_rgb_out bit i.
  typedef struct packed {
    rgb_half_t bot;
    rgb_half_t top;
  } rgb_row_t;

  localparam int GL_RGB_ROW_W = $bits(rgb_row_t);
  localparam int HUB75_ADDR_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_BLANK,
    ST_LATCH,
    ST_DISPLAY
  } row_drv_state_t;

endpackage

// File: rtl/led_display_row_driver_clk_gen.sv
// Panel shift-clock generator: toggles panel_clk every CLK_DIV system clocks
// while enabled; tick marks the last cycle of each half-period.
module led_panel_clk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk_in,
  input  logic n_reset_in,
  input  logic en,
  output logic tick,
  output logic panel_clk
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = en && (cnt == '0);

  always_ff @(posedge clk_in) begin
    if (!n_reset_in || !en) begin
      cnt       <= CNT_LOAD;
      panel_clk <= 1'b0;
    end else if (cnt == '0) begin
      cnt       <= CNT_LOAD;
      panel_clk <= ~panel_clk;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/led_display_row_driver.sv
// HUB75 row driver: shifts one top/bottom half-row pair onto the panel, then
// blanks, updates the row address, latches and holds the row on display.
//
//   state      | meaning
//   -----------+------------------------------------------------------------
//   ST_IDLE    | ready for a row; previous row (if any) still displayed
//   ST_SHIFT   | clocking column N-1 .. 0 onto the six colour lines
//   ST_BLANK   | oe_n high; row address updated on first cycle
//   ST_LATCH   | latch pulse, oe_n still high; frame_done on row 15
//   ST_DISPLAY | oe_n low for the minimum on-time
module led_display_row_driver
  import led_display_row_driver_pkg::*;
#(
  parameter int CLK_DIV       = 2,
  parameter int BLANK_CYCLES  = 4,
  parameter int LATCH_CYCLES  = 2,
  parameter int MIN_ON_CYCLES = 64
) (
  input  logic                    clk_in,
  input  logic                    n_reset_in,
  input  logic [GL_RGB_ROW_W-1:0] row_in,
  input  logic                    row_valid_in,
  output logic                    row_ready_out,
  input  logic [HUB75_ADDR_W-1:0] row_address_in,
  output logic [5:0]              panel_rgb_out,
  output logic                    panel_clk_out,
  output logic                    panel_lat_out,
  output logic                    panel_oe_n_out,
  output logic [HUB75_ADDR_W-1:0] panel_addr_out,
  output logic                    frame_done_out
);

  localparam int N       = GL_NUM_COL_PIXELS;
  localparam int BIT_W   = (N > 1) ? $clog2(N) : 1;
  localparam int MAX_BL  = (BLANK_CYCLES > LATCH_CYCLES) ? BLANK_CYCLES : LATCH_CYCLES;
  localparam int TMR_MAX = ((MAX_BL > MIN_ON_CYCLES) ? MAX_BL : MIN_ON_CYCLES) - 1;
  localparam int TMR_W   = (TMR_MAX > 0) ? $clog2(TMR_MAX + 1) : 1;

  localparam logic [TMR_W-1:0] TMR_BLANK = TMR_W'(BLANK_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_LATCH = TMR_W'(LATCH_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_ON    = TMR_W'(MIN_ON_CYCLES - 1);

  row_drv_state_t          state;
  logic [5:0][N-1:0]       sr;
  logic [BIT_W-1:0]        bit_cnt;
  logic [TMR_W-1:0]        tmr;
  logic [HUB75_ADDR_W-1:0] addr_pend;
  logic                    shown;
  logic                    shift_en;
  logic                    tick;
  logic                    pclk;

  assign shift_en      = (state == ST_SHIFT);
  assign panel_clk_out = pclk;

  led_panel_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .clk_in     (clk_in),
    .n_reset_in (n_reset_in),
    .en         (shift_en),
    .tick       (tick),
    .panel_clk  (pclk)
  );

  always_ff @(posedge clk_in) begin
    if (!n_reset_in) begin
      state          <= ST_IDLE;
      sr             <= '0;
      bit_cnt        <= '0;
      tmr            <= '0;
      addr_pend      <= '0;
      shown          <= 1'b0;
      row_ready_out  <= 1'b0;
      panel_rgb_out  <= '0;
      panel_lat_out  <= 1'b0;
      panel_oe_n_out <= 1'b1;
      panel_addr_out <= '0;
      frame_done_out <= 1'b0;
    end else begin
      frame_done_out <= 1'b0;
      case (state)
        ST_IDLE: begin
          row_ready_out  <= 1'b1;
          panel_oe_n_out <= ~shown;
          if (row_valid_in && row_ready_out) begin
            row_ready_out <= 1'b0;
            sr            <= row_in;
            addr_pend     <= row_address_in;
            bit_cnt       <= BIT_W'(N - 1);
            for (int i = 0; i < 6; i++) panel_rgb_out[i] <= row_in[i*N + N - 1];
            state         <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          // Advance only at the end of a high phase, so data moves with the falling edge.
          if (tick && pclk) begin
            if (bit_cnt == '0) begin
              panel_rgb_out  <= '0;
              panel_oe_n_out <= 1'b1;
              tmr            <= TMR_BLANK;
              state          <= ST_BLANK;
            end else begin
              bit_cnt <= bit_cnt - 1'b1;
              for (int i = 0; i < 6; i++) begin
                panel_rgb_out[i] <= sr[i][N-2];
                sr[i]            <= {sr[i][N-2:0], sr[i][N-1]};
              end
            end
          end
        end

        ST_BLANK: begin
          if (tmr == TMR_BLANK) panel_addr_out <= addr_pend;
          if (tmr == '0) begin
            panel_lat_out  <= 1'b1;
            frame_done_out <= (addr_pend == {HUB75_ADDR_W{1'b1}});
            tmr            <= TMR_LATCH;
            state          <= ST_LATCH;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end

        ST_LATCH: begin
          if (tmr == '0) begin
            panel_lat_out  <= 1'b0;
            panel_oe_n_out <= 1'b0;
            shown          <= 1'b1;
            tmr            <= TMR_ON;
            state          <= ST_DISPLAY;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end

        ST_DISPLAY: begin
          if (tmr == '0) begin
            row_ready_out <= 1'b1;
            state         <= ST_IDLE;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
